// File: rtl/chord_mixer_if.sv
// chord_mixer_if: command, control and sample bus of the chord mixer.
//   master: drives play, note, duration, new_note, beat, generate_next_sample;
//           observes sample_out, new_sample_ready, voices_active, note_stolen.
//   slave : the mixer side (directions reversed).
interface chord_mixer_if #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
);
  logic                     play;
  logic [NOTE_W-1:0]        note;
  logic [DUR_W-1:0]         duration;
  logic                     new_note;
  logic                     beat;
  logic                     generate_next_sample;
  logic signed [15:0]       sample_out;
  logic                     new_sample_ready;
  logic [NUM_VOICES-1:0]    voices_active;
  logic                     note_stolen;

  modport master (
    output play, note, duration, new_note, beat, generate_next_sample,
    input  sample_out, new_sample_ready, voices_active, note_stolen
  );

  modport slave (
    input  play, note, duration, new_note, beat, generate_next_sample,
    output sample_out, new_sample_ready, voices_active, note_stolen
  );
endinterface

// File: rtl/chord_mixer.sv
// chord_mixer: polyphonic square-wave voice allocator and mixer.
// Note commands are assigned to NUM_VOICES voices (free voice first, else the
// voice closest to expiry is stolen). Durations count down on beat while
// playing. Each sample request advances all active voices' phases and returns
// the saturated sum of +/-AMP square waves two cycles after the request edge.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - chord_mixer_if.slave (play/note/duration/new_note/beat/
//           generate_next_sample in; sample_out/new_sample_ready/
//           voices_active/note_stolen out)
module chord_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int PHASE_W    = 16,
  parameter int STEP_SHIFT = 4,
  parameter int AMP        = 8192
) (
  input  logic         clk,
  input  logic         reset,
  chord_mixer_if.slave bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W = 16 + $clog2(NUM_VOICES);
  localparam logic signed [15:0]      AMP_POS = 16'(AMP);
  localparam logic signed [15:0]      AMP_NEG = -AMP_POS;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

  logic [NUM_VOICES-1:0] active;
  logic [NOTE_W-1:0]     v_note  [NUM_VOICES];
  logic [DUR_W-1:0]      v_rem   [NUM_VOICES];
  logic [PHASE_W-1:0]    v_phase [NUM_VOICES];
  logic [PHASE_W-1:0]    v_next  [NUM_VOICES];
  logic signed [15:0]    v_samp  [NUM_VOICES];

  // pipeline: s0 = request captured, s1 = per-voice samples captured
  logic s0_valid, s0_play, s1_valid, s1_play;

  logic              accept, beat_en, found_free;
  logic [IDX_W-1:0]  free_idx, steal_idx, alloc_idx;
  logic [DUR_W-1:0]  min_rem;
  logic signed [SUM_W-1:0] sum;
  logic signed [15:0]      sat;

  assign accept  = bus.new_note && (bus.note != '0) && (bus.duration != '0);
  assign beat_en = bus.beat && bus.play;

  // Selection sees pre-beat state; strict '<' keeps ties on the lowest index.
  always_comb begin
    found_free = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!active[i] && !found_free) begin
        found_free = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    steal_idx = '0;
    min_rem   = v_rem[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (v_rem[i] < min_rem) begin
        min_rem   = v_rem[i];
        steal_idx = IDX_W'(i);
      end
    end
    alloc_idx = found_free ? free_idx : steal_idx;
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      v_next[i] = v_phase[i] + (PHASE_W'(v_note[i]) << STEP_SHIFT);
    end
  end

  // Loading a voice takes priority over both beat and phase advance on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_note[i]  <= '0;
        v_rem[i]   <= '0;
        v_phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (accept && (alloc_idx == IDX_W'(i))) begin
          active[i]  <= 1'b1;
          v_note[i]  <= bus.note;
          v_rem[i]   <= bus.duration;
          v_phase[i] <= '0;
        end else if (active[i]) begin
          if (s0_valid && s0_play) begin
            v_phase[i] <= v_next[i];
          end
          if (beat_en) begin
            v_rem[i] <= v_rem[i] - 1'b1;
            if (v_rem[i] == DUR_W'(1)) begin
              active[i]  <= 1'b0;
              v_phase[i] <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_play  <= 1'b0;
      s1_valid <= 1'b0;
      s1_play  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) v_samp[i] <= '0;
    end else begin
      s0_valid <= bus.generate_next_sample;
      s0_play  <= bus.play;
      s1_valid <= s0_valid;
      s1_play  <= s0_play;
      if (s0_valid) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!active[i] || !s0_play)   v_samp[i] <= '0;
          else if (v_next[i][PHASE_W-1]) v_samp[i] <= AMP_NEG;
          else                           v_samp[i] <= AMP_POS;
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + SUM_W'(v_samp[i]);
    if (sum > SAT_MAX)      sat = 16'sh7fff;
    else if (sum < SAT_MIN) sat = -16'sh8000;
    else                    sat = sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sample_out       <= '0;
      bus.new_sample_ready <= 1'b0;
      bus.note_stolen      <= 1'b0;
    end else begin
      bus.new_sample_ready <= s1_valid;
      if (s1_valid) bus.sample_out <= s1_play ? sat : 16'sd0;
      bus.note_stolen <= accept && !found_free;
    end
  end

  assign bus.voices_active = active;
endmodule

// File: tb/tb_chord_mixer.sv
module tb_chord_mixer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  chord_mixer_if #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) ifa ();
  chord_mixer_if #(.NUM_VOICES(4), .NOTE_W(6), .DUR_W(6)) ifb ();

  chord_mixer #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .PHASE_W(16),
                .STEP_SHIFT(4), .AMP(8192)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));

  chord_mixer #(.NUM_VOICES(4), .NOTE_W(6), .DUR_W(6), .PHASE_W(16),
                .STEP_SHIFT(4), .AMP(12000)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] act(input bit sel);
    return sel ? ifb.voices_active : {1'b0, ifa.voices_active};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cmd(input bit sel, input logic [5:0] n, input logic [5:0] d,
                     input bit with_beat);
    if (sel) begin
      ifb.note = n; ifb.duration = d; ifb.new_note = 1'b1; ifb.beat = with_beat;
    end else begin
      ifa.note = n; ifa.duration = d; ifa.new_note = 1'b1; ifa.beat = with_beat;
    end
    tick();
    ifa.new_note = 1'b0; ifa.beat = 1'b0;
    ifb.new_note = 1'b0; ifb.beat = 1'b0;
  endtask

  task automatic beat(input bit sel);
    if (sel) ifb.beat = 1'b1; else ifa.beat = 1'b1;
    tick();
    ifa.beat = 1'b0; ifb.beat = 1'b0;
  endtask

  // Request at edge T; ready must be low at T and T+1, high at T+2, low at T+3.
  task automatic do_gen(input bit sel, input logic signed [31:0] exp, input string tag);
    if (sel) ifb.generate_next_sample = 1'b1; else ifa.generate_next_sample = 1'b1;
    tick();
    ifa.generate_next_sample = 1'b0; ifb.generate_next_sample = 1'b0;
    chk({tag, "_rdy_t0"}, sel ? ifb.new_sample_ready : ifa.new_sample_ready, 0);
    tick();
    chk({tag, "_rdy_t1"}, sel ? ifb.new_sample_ready : ifa.new_sample_ready, 0);
    tick();
    chk({tag, "_rdy_t2"}, sel ? ifb.new_sample_ready : ifa.new_sample_ready, 1);
    chk({tag, "_sample"}, sel ? ifb.sample_out : ifa.sample_out, exp);
    tick();
    chk({tag, "_rdy_t3"}, sel ? ifb.new_sample_ready : ifa.new_sample_ready, 0);
  endtask

  initial begin
    reset = 1'b0;
    ifa.play = 1'b1; ifa.note = '0; ifa.duration = '0; ifa.new_note = 1'b0;
    ifa.beat = 1'b0; ifa.generate_next_sample = 1'b0;
    ifb.play = 1'b1; ifb.note = '0; ifb.duration = '0; ifb.new_note = 1'b0;
    ifb.beat = 1'b0; ifb.generate_next_sample = 1'b0;

    // reset state and idle samples
    do_reset();
    chk("rst_sample", ifa.sample_out, 0);
    chk("rst_ready", ifa.new_sample_ready, 0);
    chk("rst_active", act(0), 0);
    chk("rst_stolen", ifa.note_stolen, 0);
    chk("rst_active_b", act(1), 0);
    for (int i = 0; i < 2; i++) do_gen(0, 0, "idle");
    chk("idle_active", act(0), 0);

    // filtered commands
    cmd(0, 6'd0, 6'd5, 0);
    chk("filt_rest", act(0), 0);
    cmd(0, 6'd5, 6'd0, 0);
    chk("filt_dur0", act(0), 0);

    // single note, expiry after 4 beats
    cmd(0, 6'd37, 6'd4, 0);
    chk("one_active", act(0), 3'b001);
    chk("one_nosteal", ifa.note_stolen, 0);
    do_gen(0, 8192, "one_first");
    for (int i = 0; i < 3; i++) beat(0);
    chk("one_3beats", act(0), 3'b001);
    beat(0);
    chk("one_expired", act(0), 3'b000);
    do_gen(0, 0, "one_after");

    // chord
    cmd(0, 6'd37, 6'd4, 0);
    cmd(0, 6'd41, 6'd4, 0);
    cmd(0, 6'd44, 6'd4, 0);
    chk("chord_active", act(0), 3'b111);
    do_gen(0, 24576, "chord");

    // phase MSB flips on the 56th sample of note 37 (592*56 >= 32768)
    do_reset();
    cmd(0, 6'd37, 6'd63, 0);
    for (int i = 1; i <= 56; i++) do_gen(0, (i < 56) ? 8192 : -8192, "wrap");

    // stealing: smallest remaining (voice 1) is evicted
    do_reset();
    cmd(0, 6'd37, 6'd4, 0);
    cmd(0, 6'd41, 6'd2, 0);
    cmd(0, 6'd44, 6'd6, 0);
    chk("steal_full", act(0), 3'b111);
    cmd(0, 6'd9, 6'd0, 0);
    chk("steal_filt_nopulse", ifa.note_stolen, 0);
    cmd(0, 6'd50, 6'd3, 0);
    chk("steal_pulse", ifa.note_stolen, 1);
    chk("steal_active", act(0), 3'b111);
    tick();
    chk("steal_pulse_end", ifa.note_stolen, 0);
    beat(0);
    beat(0);
    chk("steal_2beats", act(0), 3'b111);
    beat(0);
    chk("steal_v1_expired", act(0), 3'b101);

    // allocation in the same cycle as a beat
    do_reset();
    cmd(0, 6'd41, 6'd2, 0);
    beat(0);
    chk("same_pre", act(0), 3'b001);
    cmd(0, 6'd41, 6'd2, 1);
    chk("same_alloc", act(0), 3'b010);
    chk("same_nosteal", ifa.note_stolen, 0);
    beat(0);
    chk("same_1beat", act(0), 3'b010);
    beat(0);
    chk("same_expired", act(0), 3'b000);

    // four voices, saturation, pause and resume
    cmd(1, 6'd37, 6'd3, 0);
    cmd(1, 6'd41, 6'd3, 0);
    cmd(1, 6'd44, 6'd3, 0);
    cmd(1, 6'd50, 6'd3, 0);
    chk("b_active", act(1), 4'b1111);
    do_gen(1, 32767, "b_sat");
    ifb.play = 1'b0;
    do_gen(1, 0, "b_paused");
    for (int i = 0; i < 4; i++) beat(1);
    chk("b_paused_beats", act(1), 4'b1111);
    ifb.play = 1'b1;
    beat(1);
    beat(1);
    chk("b_resume_2", act(1), 4'b1111);
    beat(1);
    chk("b_resume_3", act(1), 4'b0000);
    do_gen(1, 0, "b_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chord_mixer.md
# chord_mixer

Parametrised polyphonic voice allocator and mixer for the note-player datapath, replacing the fixed three-note chords block. It accepts note/duration commands, assigns each to one of NUM_VOICES internal square-wave voices, and counts each voice's duration down on the beat pulse. On every sample request it advances all active voices and returns their saturated sum as one signed sample. Voice stealing handles the case where more notes arrive than there are voices.

## Interface
- NUM_VOICES, 3: number of simultaneous voices (1..8).
- NOTE_W, 6: note code width; code 0 is a rest.
- DUR_W, 6: duration width, in beats.
- PHASE_W, 16: phase accumulator width per voice.
- STEP_SHIFT, 4: phase step is note << STEP_SHIFT, truncated to PHASE_W.
- AMP, 8192: square-wave amplitude, positive, < 2^15.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- play  in  1  1 = run; 0 = pause. While paused, counters and phases freeze and output samples are 0.
- note  in  NOTE_W  note code, sampled when new_note=1.
- duration  in  DUR_W  length in beats, sampled when new_note=1.
- new_note  in  1  one-cycle command strobe.
- beat  in  1  one-cycle beat tick.
- generate_next_sample  in  1  one-cycle sample request.
- sample_out  out  16  signed mixed sample; held between updates.
- new_sample_ready  out  1  one-cycle pulse when sample_out updates.
- voices_active  out  NUM_VOICES  bit i = voice i busy.
- note_stolen  out  1  one-cycle pulse when an allocation evicted a busy voice.

## Operation
- Per-voice state: active, note, remaining (DUR_W), phase (PHASE_W).
- Command filter: new_note with note=0 or duration=0 is ignored. No state changes and no pulse.
- Allocation: a command goes to the lowest-index inactive voice.
- Stealing: if all voices are active, the command goes to the active voice with the smallest remaining; ties go to the lowest index. note_stolen pulses on the next cycle.
- On allocation: note and remaining are loaded, phase is cleared to 0, and active is set to 1.
- Allocation is accepted regardless of play.
- Beat, when play=1: every active voice decrements remaining. A voice whose remaining goes 1→0 clears active and its phase.
- Beat is ignored when play=0.
- Allocation and beat in the same cycle:
  - Free/steal selection uses the pre-beat state.
  - The beat decrement applies to all other voices.
  - The newly loaded voice keeps its full duration; it is not decremented that cycle.
- Sample generation, on generate_next_sample with play=1:
  - Each active voice does phase += note << STEP_SHIFT, with modulo-2^PHASE_W wrap.
  - The voice sample uses the updated phase: MSB=0 gives +AMP, MSB=1 gives −AMP. An inactive voice contributes 0.
  - The sum is accumulated at 16+clog2(NUM_VOICES) bits signed, then saturated to [−32768, 32767].
- generate_next_sample with play=0: phases hold, the result is 0, and new_sample_ready still pulses.
- Reset mid-operation: all voices go inactive and all pending pipeline results are discarded.

## Timing
- Reset values: sample_out=0, new_sample_ready=0, voices_active=0, note_stolen=0, all voice state cleared.
- Sample pipeline:
  - The request is sampled at edge T.
  - Phases and per-voice samples are registered at edge T+1.
  - sample_out and new_sample_ready=1 are registered at edge T+2.
  - new_sample_ready deasserts at T+3.
- Requests closer together than 2 cycles are not supported. Upstream guarantees a spacing of ≥ 4 cycles.
- Allocation: voices_active reflects a command one cycle after the new_note edge.
- Beat: voices_active reflects expiry one cycle after the beat edge.
- A note allocated at or before request edge T contributes to the sample produced at T+2.

## Test plan
- Reset for 1 cycle, then idle 10 cycles with gen pulses → sample_out=0, new_sample_ready pulses 2 cycles after each request, voices_active=3'b000.
- note=37, dur=4, then a gen pulse → voices_active=3'b001, first sample_out=+8192 (phase 592). After the 4th beat, voices_active=0 and the next sample is 0. Phase MSB first flips after 56 samples → −8192.
- Chord of note 37, 41, 44 at dur=4 → voices_active=3'b111, first sample=+24576.
- Durations 4, 2, 6 active, then note=50, dur=3 → voice 1 is replaced, note_stolen pulses once, voices_active stays 3'b111.
- NUM_VOICES=4, AMP=12000, four notes → sample saturates at +32767. With play=0, the next sample is 0, beats do not decrement, and after play=1 durations resume from their held values.
- new_note (note=41, dur=2) in the same cycle as a beat, with one voice at remaining=1 and the others free:
  - The new note takes a free voice.
  - The old voice expires.
  - The new voice shows remaining=2 and is still active after one further beat.
